// File: rtl/filtro_promedio_adc_if.sv
// Handshake bundle between the sampling/averaging controller and its surroundings.
// master: the filter side (drives start and results); slave: ADC reader / consumer side.
interface filtro_promedio_adc_if;
  logic        enable;
  logic        done;
  logic [11:0] Dato;
  logic        start;
  logic [11:0] Promedio;
  logic        valido;
  logic        lleno;
  logic        error_timeout;

  modport master (
    input  enable, done, Dato,
    output start, Promedio, valido, lleno, error_timeout
  );

  modport slave (
    output enable, done, Dato,
    input  start, Promedio, valido, lleno, error_timeout
  );
endinterface

// File: rtl/filtro_promedio_adc.sv
// Periodic ADC sampling controller with a 2^N_LOG2-sample moving-average filter.
// Optional ESPERA watchdog built only when FILTRO_TIMEOUT_EN is defined.
//
// state     | meaning
// IDLE      | waiting for enable
// ARRANQUE  | one-cycle start request, period timer loaded
// ESPERA    | waiting for a rising edge of done
// ACTUALIZA | window, running sum and average update
// PAUSA     | waiting for the period timer to expire
module filtro_promedio_adc #(
  parameter int N_LOG2  = 3,
  parameter int PERIODO = 64,
  parameter int TIMEOUT = 255
) (
  input  logic Clock_Muestreo,
  input  logic reset,
  filtro_promedio_adc_if.master bus
);

  localparam int VENTANA = 1 << N_LOG2;
  localparam int SW      = 12 + N_LOG2;
  localparam int CW      = N_LOG2 + 1;
  localparam int PW      = $clog2(PERIODO);

  typedef enum logic [2:0] {IDLE, ARRANQUE, ESPERA, ACTUALIZA, PAUSA} estado_t;

  estado_t           estado, estado_sig;
  logic              done_q, flanco, captura, timeout_evt;
  logic [11:0]       muestra;
  logic [11:0]       buffer [VENTANA];
  logic [N_LOG2-1:0] ptr;
  logic [CW-1:0]     cuenta, cuenta_sig;
  logic [SW-1:0]     suma, suma_sig;
  logic [PW-1:0]     per_cnt;
  logic [11:0]       promedio_q;
  logic              valido_q, lleno_q;

  assign flanco     = bus.done & ~done_q;
  assign suma_sig   = suma + SW'(muestra) - SW'(buffer[ptr]);
  assign cuenta_sig = (cuenta == CW'(VENTANA)) ? cuenta : cuenta + CW'(1);

  always_ff @(posedge Clock_Muestreo or posedge reset) begin
    if (reset) estado <= IDLE;
    else       estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    captura    = 1'b0;
    case (estado)
      IDLE:      if (bus.enable) estado_sig = ARRANQUE;
      ARRANQUE:  estado_sig = ESPERA;
      ESPERA: begin
        if (flanco) begin
          captura    = 1'b1;
          estado_sig = ACTUALIZA;
        end else if (timeout_evt) begin
          estado_sig = PAUSA;
        end
      end
      ACTUALIZA: estado_sig = PAUSA;
      PAUSA:     if (per_cnt == '0) estado_sig = bus.enable ? ARRANQUE : IDLE;
      default:   estado_sig = IDLE;
    endcase
  end

  assign bus.start    = (estado == ARRANQUE);
  assign bus.Promedio = promedio_q;
  assign bus.valido   = valido_q;
  assign bus.lleno    = lleno_q;

  // Loaded with PERIODO-2 so that PAUSA expiring on zero lands the next start PERIODO cycles later.
  always_ff @(posedge Clock_Muestreo or posedge reset) begin
    if (reset)                   per_cnt <= '0;
    else if (estado == ARRANQUE) per_cnt <= PW'(PERIODO - 2);
    else if (per_cnt != '0)      per_cnt <= per_cnt - PW'(1);
  end

  always_ff @(posedge Clock_Muestreo or posedge reset) begin
    if (reset) begin
      done_q     <= 1'b0;
      muestra    <= '0;
      ptr        <= '0;
      cuenta     <= '0;
      suma       <= '0;
      promedio_q <= '0;
      valido_q   <= 1'b0;
      lleno_q    <= 1'b0;
      for (int i = 0; i < VENTANA; i++) buffer[i] <= '0;
    end else begin
      done_q   <= bus.done;
      valido_q <= 1'b0;
      if (captura) muestra <= bus.Dato;
      if (estado == ACTUALIZA) begin
        suma        <= suma_sig;
        buffer[ptr] <= muestra;
        ptr         <= ptr + N_LOG2'(1);
        cuenta      <= cuenta_sig;
        if (cuenta_sig == CW'(VENTANA)) begin
          promedio_q <= suma_sig[SW-1:N_LOG2];
          valido_q   <= 1'b1;
          lleno_q    <= 1'b1;
        end
      end
    end
  end

`ifdef FILTRO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wd_cnt;
  logic          error_q;

  assign timeout_evt       = (estado == ESPERA) && !flanco && (wd_cnt == '0);
  assign bus.error_timeout = error_q;

  always_ff @(posedge Clock_Muestreo or posedge reset) begin
    if (reset) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      if (estado == ARRANQUE)                   wd_cnt <= TW'(TIMEOUT - 1);
      else if (estado == ESPERA && wd_cnt != '0) wd_cnt <= wd_cnt - TW'(1);
      if (timeout_evt) error_q <= 1'b1;
    end
  end
`else
  // TIMEOUT only matters for the watchdog build.
  logic unused_timeout;
  assign unused_timeout    = (TIMEOUT > 0);
  assign timeout_evt       = 1'b0;
  assign bus.error_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_filtro_promedio_adc.sv
// Bench for filtro_promedio_adc: ADC responder plus queue-based window/average model.
module tb_filtro_promedio_adc;

  logic Clock_Muestreo = 1'b0;
  logic reset;

  filtro_promedio_adc_if bus();

  filtro_promedio_adc #(.N_LOG2(3), .PERIODO(64), .TIMEOUT(255)) dut (
    .Clock_Muestreo(Clock_Muestreo),
    .reset         (reset),
    .bus           (bus)
  );

  initial forever #5 Clock_Muestreo = ~Clock_Muestreo;

  int ciclo = 0;
  always @(posedge Clock_Muestreo) ciclo <= ciclo + 1;

  int          checks = 0;
  int          errores = 0;
  int          cola[$];
  logic [11:0] exp_prom = '0;
  int          prev_start = 0;
  int          prev_ret = 0;
  bit          encadenado = 0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errores++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic esperar_start(output int s, output bit ok);
    ok = 0;
    s  = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus.start === 1'b1) begin
        ok = 1;
        s  = ciclo;
        break;
      end
      @(negedge Clock_Muestreo);
    end
  endtask

  // One conversion: done rises retardo cycles after start and is held for ancho cycles.
  task automatic conversion(input int retardo, input logic [11:0] valor, input int ancho,
                            input bit soltar_en);
    int s, suma_m, largo;
    bit ok;
    esperar_start(s, ok);
    comprobar("start_visto", 32'(ok), 32'd1);
    if (!ok) return;
    if (encadenado) comprobar("espaciado", 32'(s - prev_start), 32'(max2(64, prev_ret + 3)));
    prev_start = s;
    prev_ret   = retardo;
    encadenado = 1;
    if (soltar_en) bus.enable = 1'b0;
    repeat (retardo) @(negedge Clock_Muestreo);
    bus.done = 1'b1;
    bus.Dato = valor;
    cola.push_back(int'(valor));
    if (cola.size() > 8) void'(cola.pop_front());
    if (cola.size() == 8) begin
      suma_m = 0;
      foreach (cola[i]) suma_m += cola[i];
      exp_prom = 12'(suma_m / 8);
    end
    largo = max2(ancho, 3);
    for (int k = 1; k <= largo; k++) begin
      @(negedge Clock_Muestreo);
      if (k == ancho) begin
        bus.done = 1'b0;
        bus.Dato = 12'($urandom);
      end
      if (k == 1) comprobar("valido_t1", 32'(bus.valido), 32'd0);
      if (k == 2) begin
        comprobar("valido", 32'(bus.valido), 32'(cola.size() == 8));
        comprobar("promedio", 32'(bus.Promedio), 32'(exp_prom));
        comprobar("lleno", 32'(bus.lleno), 32'(cola.size() == 8));
      end
      if (k == 3) comprobar("valido_pulso", 32'(bus.valido), 32'd0);
    end
  endtask

  task automatic conversion_aleatoria();
    int r, a;
    r = int'($urandom_range(1, 80));
    a = (r <= 40) ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 3));
    conversion(r, 12'($urandom), a, 1'b0);
  endtask

  initial begin
    int s, s2, vistos;
    bit ok;
    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.done   = 1'b0;
    bus.Dato   = '0;
    repeat (3) @(negedge Clock_Muestreo);
    comprobar("rst_start", 32'(bus.start), 32'd0);
    comprobar("rst_promedio", 32'(bus.Promedio), 32'd0);
    comprobar("rst_valido", 32'(bus.valido), 32'd0);
    comprobar("rst_lleno", 32'(bus.lleno), 32'd0);
    comprobar("rst_error", 32'(bus.error_timeout), 32'd0);
    reset = 1'b0;
    @(negedge Clock_Muestreo);
    bus.enable = 1'b1;

    for (int i = 0; i < 8; i++) conversion(20, 12'h800, 1, 1'b0);
    comprobar("prom_800", 32'(bus.Promedio), 32'h800);
    for (int i = 0; i < 4; i++) conversion(20, 12'hFFF, 1, 1'b0);
    comprobar("prom_bff", 32'(bus.Promedio), 32'hBFF);
    for (int i = 0; i < 4; i++) conversion(20, 12'hFFF, 1, 1'b0);
    comprobar("prom_fff", 32'(bus.Promedio), 32'hFFF);

    conversion(70, 12'($urandom), 1, 1'b0);
    conversion(20, 12'($urandom), 1, 1'b0);
    conversion(20, 12'h123, 10, 1'b0);
    conversion(20, 12'h456, 1, 1'b0);

    for (int i = 0; i < 20; i++) conversion_aleatoria();

    conversion(30, 12'($urandom), 1, 1'b1);
    vistos = 0;
    repeat (150) begin
      @(negedge Clock_Muestreo);
      if (bus.start === 1'b1) vistos++;
    end
    comprobar("sin_start_deshabilitado", 32'(vistos), 32'd0);
    bus.enable = 1'b1;
    encadenado = 0;
    for (int i = 0; i < 3; i++) conversion_aleatoria();
    comprobar("lleno_retenido", 32'(bus.lleno), 32'd1);

    for (int i = 0; i < 5; i++) conversion_aleatoria();
    esperar_start(s, ok);
    comprobar("start_antes_reset", 32'(ok), 32'd1);
    repeat (10) @(negedge Clock_Muestreo);
    reset = 1'b1;
    #1;
    comprobar("rst_medio_start", 32'(bus.start), 32'd0);
    comprobar("rst_medio_promedio", 32'(bus.Promedio), 32'd0);
    comprobar("rst_medio_valido", 32'(bus.valido), 32'd0);
    comprobar("rst_medio_lleno", 32'(bus.lleno), 32'd0);
    comprobar("rst_medio_error", 32'(bus.error_timeout), 32'd0);
    @(negedge Clock_Muestreo);
    reset = 1'b0;
    cola.delete();
    exp_prom   = '0;
    encadenado = 0;
    for (int i = 0; i < 8; i++) conversion_aleatoria();

    esperar_start(s, ok);
    comprobar("start_sin_done", 32'(ok), 32'd1);
`ifdef FILTRO_TIMEOUT_EN
    for (int i = 1; i <= 256; i++) begin
      @(negedge Clock_Muestreo);
      if (i == 255) comprobar("error_antes", 32'(bus.error_timeout), 32'd0);
      if (i == 256) comprobar("error_timeout", 32'(bus.error_timeout), 32'd1);
    end
    esperar_start(s2, ok);
    comprobar("reintento_visto", 32'(ok), 32'd1);
    comprobar("reintento_ciclo", 32'(s2 - s), 32'd257);
    @(negedge Clock_Muestreo);
    comprobar("error_pegajoso", 32'(bus.error_timeout), 32'd1);
`else
    s2 = s;
    vistos = 0;
    repeat (400) begin
      @(negedge Clock_Muestreo);
      if (bus.start === 1'b1) vistos++;
    end
    comprobar("espera_indefinida", 32'(vistos), 32'd0);
    comprobar("error_timeout_cero", 32'(bus.error_timeout), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errores);
    $finish;
  end

endmodule
